// File: rtl/ser_pkg.sv
// Shared types and constants for the serial deserializer.
package ser_pkg;

  // Output buffer occupancy
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Bit-order modes for the LSB_FIRST parameter
  localparam bit LSB_FIRST_MODE = 1'b1;
  localparam bit MSB_FIRST_MODE = 1'b0;

endpackage

// File: rtl/serial_shift_core.sv
// Direction-selectable shift register that collects serial bits.
module serial_shift_core
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = LSB_FIRST_MODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_shifted;

  // New bits enter at the top when LSB-first so the first bit ends in bit 0
  if (LSB_FIRST == LSB_FIRST_MODE) begin : g_lsb
    assign sr_shifted = {serial_in, sr_q[WIDTH-1:1]};
  end else begin : g_msb
    assign sr_shifted = {sr_q[WIDTH-2:0], serial_in};
  end

  // Next-state: clear wins, otherwise shift only on enable
  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = sr_shifted;
    end
  end

  // Shift register state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter with a one-word output buffer and sticky overflow.
module serial_deserializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = LSB_FIRST_MODE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     bit_valid,
  input  logic                     serial_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic             shift_en;
  logic             word_done;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] full_word;

  logic [CW-1:0]    count_q, count_d;
  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  assign shift_en  = bit_valid & ~clear;
  assign word_done = shift_en & (count_q == LAST_BIT);

  serial_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .q         (shift_q)
  );

  // Completed word including the bit being sampled on the completing edge
  if (LSB_FIRST == LSB_FIRST_MODE) begin : g_lsb
    assign full_word = {serial_in, shift_q[WIDTH-1:1]};
  end else begin : g_msb
    assign full_word = {shift_q[WIDTH-2:0], serial_in};
  end

  // Bit counter, output buffer FSM and overflow next-state
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;

    if (clear) begin
      count_d = '0;
      state_d = OUT_EMPTY;
      data_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (shift_en) begin
        count_d = word_done ? '0 : count_q + CW'(1);
      end

      case (state_q)
        OUT_EMPTY: begin
          if (word_done) begin
            state_d = OUT_FULL;
            data_d  = full_word;
          end
        end
        OUT_FULL: begin
          if (word_done) begin
            // Same-cycle consume lets the new word replace the old without a bubble
            if (out_ready) begin
              data_d = full_word;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (out_ready) begin
            state_d = OUT_EMPTY;
          end
        end
        default: state_d = OUT_EMPTY;
      endcase
    end
  end

  // Registered control and output state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = (state_q == OUT_FULL);
  assign bit_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits; legal range 2..32.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = first received bit lands in data_out[0], 0 = first received bit lands in data_out[WIDTH-1].
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous flush of partial word, output buffer and overflow.
REQ-006 SHALL have port bit_valid  input  1  serial_in is sampled this cycle.
REQ-007 SHALL have port serial_in  input  1  serial data bit.
REQ-008 SHALL have port data_out  output  WIDTH  assembled word, registered.
REQ-009 SHALL have port out_valid  output  1  data_out holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts data_out when out_valid=1.
REQ-011 SHALL have port bit_count  output  $clog2(WIDTH)  bits of current partial word received.
REQ-012 SHALL have port overflow  output  1  sticky; a completed word was dropped.

Function
REQ-013 SHALL shift serial_in into the internal shift register only on rising edges where bit_valid=1; bit_valid=0 holds all shift/count state.
REQ-014 LSB_FIRST=1: shift right, serial_in enters bit WIDTH-1; LSB_FIRST=0: shift left, serial_in enters bit 0.
REQ-015 bit_count SHALL increment per accepted bit, wrap from WIDTH-1 to 0 on the completing (WIDTH-th) bit.
REQ-016 On the completing bit, the full word (including that bit) SHALL be written to data_out and out_valid set at the same edge; visible the cycle after the WIDTH-th bit is sampled (latency 1).
REQ-017 Output buffer FSM SHALL have states OUT_EMPTY (out_valid=0) and OUT_FULL (out_valid=1).
REQ-018 OUT_EMPTY -> OUT_FULL on word completion; OUT_FULL -> OUT_EMPTY on out_ready=1 with no completion in the same cycle.
REQ-019 OUT_FULL with out_ready=1 and completion in the same cycle SHALL load the new word and remain OUT_FULL (no bubble, no overflow).
REQ-020 OUT_FULL with out_ready=0 and completion SHALL drop the new word, keep data_out unchanged, set overflow; shift/count still wrap to 0.
REQ-021 overflow SHALL stay 1 until reset or clear.
REQ-022 data_out SHALL hold its last value while OUT_EMPTY.
REQ-023 clear=1 SHALL take priority over bit_valid and out_ready: shift register, bit_count, out_valid, overflow -> 0; data_out -> 0; serial_in that cycle discarded.
REQ-024 out_ready while OUT_EMPTY SHALL have no effect.

Reset
REQ-025 reset=1 SHALL asynchronously force shift register=0, bit_count=0, data_out=0, out_valid=0, overflow=0, FSM=OUT_EMPTY.
REQ-026 Reset mid-word SHALL discard the partial word; first bit after deassertion is bit 0 of a new word.

Structure
REQ-027 Output FSM state enum and a LSB_FIRST/MSB_FIRST mode constant pair SHALL live in shared package ser_pkg.
REQ-028 Shift register with direction parameter SHALL be sub-module serial_shift_core (params WIDTH, LSB_FIRST; ports clk, reset, clear, shift_en, serial_in, q); counter and output FSM remain in top.

Verification (WIDTH=8 unless noted)
REQ-029 LSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=0 -> data_out=0xA5, out_valid=1 one cycle after 8th bit, bit_count=0.
REQ-030 LSB_FIRST=0, same bit sequence -> data_out=0xA5 read as MSB-first, i.e. 0b10100101 = 0xA5; then sequence 1,1,0,0,0,0,0,0 -> 0xC0.
REQ-031 bit_valid gaps of 3 idle cycles between bits of 0x3C -> data_out=0x3C, bit_count holds during gaps.
REQ-032 Word 0x11 unconsumed, then 0x22 completes with out_ready=0 -> data_out=0x11, overflow=1; with out_ready=1 on completion cycle instead -> data_out=0x22, overflow=0, out_valid stays 1.
REQ-033 reset asserted after 5 bits, released, then 8 bits of 0xF0 -> data_out=0xF0, no stale bits; clear after 3 bits behaves identically.
REQ-034 WIDTH=2: bits 1,0 -> data_out=0b01 (LSB_FIRST=1); back-to-back words with out_ready=1 -> new word every 2 bit_valid cycles, out_valid continuous.
